// File: rtl/jelly2_texture_cache_pkg.sv
// ---------------------------------------------------------------------------
// jelly2_texture_cache_pkg
//   Shared definitions for the texture cache front end.
//   - ARB_MODE_* : string names accepted by the arbiter ARB_MODE parameter
//   - port_tag_width() : number of bits used to tag a request with its port
// ---------------------------------------------------------------------------
package jelly2_texture_cache_pkg;

    localparam string ARB_MODE_ROUND_ROBIN = "ROUND_ROBIN";
    localparam string ARB_MODE_FIXED       = "FIXED";

    // A single port still carries a one-bit tag so the user field layout
    // never collapses to zero width.
    function automatic int port_tag_width(input int port_num);
        return (port_num > 1) ? $clog2(port_num) : 1;
    endfunction

endpackage

// File: rtl/jelly2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// jelly2_rr_arbiter
//   Purely combinational grant over an N-bit request vector.
//   Ports:
//     i_request      : request vector, one bit per requester
//     i_rr_ptr       : round-robin start index (ignored when FIXED = 1)
//     o_grant_valid  : at least one request was granted
//     o_grant_onehot : one-hot grant
//     o_grant_index  : encoded grant index
// ---------------------------------------------------------------------------
module jelly2_rr_arbiter
    import jelly2_texture_cache_pkg::*;
    #(
        parameter int N     = 4,
        parameter int BITS  = port_tag_width(N),
        parameter bit FIXED = 1'b0
    )
    (
        input  logic [N-1:0]    i_request,
        input  logic [BITS-1:0] i_rr_ptr,
        output logic            o_grant_valid,
        output logic [N-1:0]    o_grant_onehot,
        output logic [BITS-1:0] o_grant_index
    );

    // Walk the requesters starting at the pointer (or at 0 in fixed mode),
    // wrapping once around, and keep the first one found. The pointer is
    // always below N, so a single subtraction is enough for the wrap.
    always_comb begin : p_grant
        int        w_idx;
        logic [BITS-1:0] w_sel;
        w_idx          = 0;
        w_sel          = '0;
        o_grant_valid  = 1'b0;
        o_grant_onehot = '0;
        o_grant_index  = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = FIXED ? k : int'(i_rr_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = BITS'(w_idx);
            if (!o_grant_valid && i_request[w_sel]) begin
                o_grant_valid         = 1'b1;
                o_grant_onehot[w_sel] = 1'b1;
                o_grant_index         = w_sel;
            end
        end
    end

endmodule

// File: rtl/jelly2_texture_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// jelly2_texture_cache_port_arbiter
//   Lets PORT_NUM texture samplers share one jelly2_texture_cache_unit.
//   Ports:
//     reset, clk          : asynchronous active-high reset, single clock
//     s_ar*  (per port)   : read-address requests from the samplers
//     s_r*   (per port)   : read data back to the samplers (rvalid per port,
//                           payload broadcast)
//     m_ar*               : one registered request towards the cache, the
//                           user field carries {port, user}
//     m_r*                : read data from the cache, routed by port tag
//     status_busy         : requests in flight or pending
//     status_error        : sticky, a beat carried a nonexistent port tag
// ---------------------------------------------------------------------------
module jelly2_texture_cache_port_arbiter
    import jelly2_texture_cache_pkg::*;
    #(
        parameter int    PORT_NUM        = 4,
        parameter int    S_USER_WIDTH    = 1,
        parameter int    ADDR_X_WIDTH    = 12,
        parameter int    ADDR_Y_WIDTH    = 12,
        parameter int    DATA_WIDTH      = 24,
        parameter int    STRB_WIDTH      = 1,
        parameter string ARB_MODE        = "ROUND_ROBIN",
        parameter int    MAX_OUTSTANDING = 16,
        localparam int   PORT_BITS       = port_tag_width(PORT_NUM),
        localparam int   CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
    )
    (
        input  logic                                reset,
        input  logic                                clk,

        input  logic [PORT_NUM*S_USER_WIDTH-1:0]    s_aruser,
        input  logic [PORT_NUM*ADDR_X_WIDTH-1:0]    s_araddrx,
        input  logic [PORT_NUM*ADDR_Y_WIDTH-1:0]    s_araddry,
        input  logic [PORT_NUM-1:0]                 s_arstrb,
        input  logic [PORT_NUM-1:0]                 s_arvalid,
        output logic [PORT_NUM-1:0]                 s_arready,

        output logic [PORT_NUM*S_USER_WIDTH-1:0]    s_ruser,
        output logic [PORT_NUM-1:0]                 s_rlast,
        output logic [PORT_NUM*DATA_WIDTH-1:0]      s_rdata,
        output logic [PORT_NUM*STRB_WIDTH-1:0]      s_rstrb,
        output logic [PORT_NUM-1:0]                 s_rvalid,
        input  logic [PORT_NUM-1:0]                 s_rready,

        output logic [S_USER_WIDTH+PORT_BITS-1:0]   m_aruser,
        output logic [ADDR_X_WIDTH-1:0]             m_araddrx,
        output logic [ADDR_Y_WIDTH-1:0]             m_araddry,
        output logic                                m_arstrb,
        output logic                                m_arvalid,
        input  logic                                m_arready,

        input  logic [S_USER_WIDTH+PORT_BITS-1:0]   m_ruser,
        input  logic                                m_rlast,
        input  logic [DATA_WIDTH-1:0]               m_rdata,
        input  logic [STRB_WIDTH-1:0]               m_rstrb,
        input  logic                                m_rvalid,
        output logic                                m_rready,

        output logic                                status_busy,
        output logic                                status_error
    );

    // Anything that is not exactly "ROUND_ROBIN" falls back to fixed
    // priority, which is the deterministic choice.
    localparam bit FIXED_MODE = (ARB_MODE == ARB_MODE_FIXED) ||
                                (ARB_MODE != ARB_MODE_ROUND_ROBIN);

    logic [CNT_WIDTH-1:0]              r_cnt [PORT_NUM];
    logic [PORT_BITS-1:0]              r_rr_ptr;
    logic                              r_m_arvalid;
    logic [S_USER_WIDTH+PORT_BITS-1:0] r_m_aruser;
    logic [ADDR_X_WIDTH-1:0]           r_m_araddrx;
    logic [ADDR_Y_WIDTH-1:0]           r_m_araddry;
    logic                              r_m_arstrb;
    logic                              r_status_error;

    logic                              w_load_en;
    logic [PORT_NUM-1:0]               w_elig;
    logic [PORT_NUM-1:0]               w_request;
    logic                              w_grant_valid;
    logic [PORT_NUM-1:0]               w_grant_onehot;
    logic [PORT_BITS-1:0]              w_grant_index;
    logic [S_USER_WIDTH-1:0]           w_sel_user;
    logic [ADDR_X_WIDTH-1:0]           w_sel_addrx;
    logic [ADDR_Y_WIDTH-1:0]           w_sel_addry;
    logic                              w_sel_strb;
    logic [PORT_BITS-1:0]              w_rp;
    logic                              w_rp_valid;
    logic                              w_m_rready;
    logic [PORT_NUM-1:0]               w_inc;
    logic [PORT_NUM-1:0]               w_dec;
    logic                              w_busy;

    assign w_load_en = !r_m_arvalid || m_arready;

    // A port competes only while it is below its outstanding limit, and
    // nobody competes while the output register is holding a request.
    always_comb begin
        w_elig    = '0;
        w_request = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_elig[p] = s_arvalid[p] && (r_cnt[p] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
        if (w_load_en) begin
            w_request = w_elig;
        end
    end

    jelly2_rr_arbiter
        #(
            .N      (PORT_NUM),
            .BITS   (PORT_BITS),
            .FIXED  (FIXED_MODE)
        )
        u_arbiter
        (
            .i_request      (w_request),
            .i_rr_ptr       (r_rr_ptr),
            .o_grant_valid  (w_grant_valid),
            .o_grant_onehot (w_grant_onehot),
            .o_grant_index  (w_grant_index)
        );

    assign s_arready = w_grant_onehot;

    // Select the payload of the granted port for the output register.
    always_comb begin
        w_sel_user  = '0;
        w_sel_addrx = '0;
        w_sel_addry = '0;
        w_sel_strb  = 1'b0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_grant_onehot[p]) begin
                w_sel_user  = s_aruser [p*S_USER_WIDTH +: S_USER_WIDTH];
                w_sel_addrx = s_araddrx[p*ADDR_X_WIDTH +: ADDR_X_WIDTH];
                w_sel_addry = s_araddry[p*ADDR_Y_WIDTH +: ADDR_Y_WIDTH];
                w_sel_strb  = s_arstrb[p];
            end
        end
    end

    // One-entry output register. A grant loads it, an accepted request with
    // no replacement drains it, otherwise it holds for the cache.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_arvalid <= 1'b0;
            r_m_aruser  <= '0;
            r_m_araddrx <= '0;
            r_m_araddry <= '0;
            r_m_arstrb  <= 1'b0;
        end else if (w_grant_valid) begin
            r_m_arvalid <= 1'b1;
            r_m_aruser  <= {w_grant_index, w_sel_user};
            r_m_araddrx <= w_sel_addrx;
            r_m_araddry <= w_sel_addry;
            r_m_arstrb  <= w_sel_strb;
        end else if (m_arready) begin
            r_m_arvalid <= 1'b0;
        end
    end

    // The round-robin pointer moves just past the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_valid) begin
            if (32'(w_grant_index) == PORT_NUM - 1) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_grant_index + 1'b1;
            end
        end
    end

    assign m_arvalid = r_m_arvalid;
    assign m_aruser  = r_m_aruser;
    assign m_araddrx = r_m_araddrx;
    assign m_araddry = r_m_araddry;
    assign m_arstrb  = r_m_arstrb;

    // Read data is routed by the port tag. A tag naming a port that does
    // not exist is swallowed so the cache never stalls on it.
    assign w_rp       = m_ruser[S_USER_WIDTH +: PORT_BITS];
    assign w_rp_valid = (32'(w_rp) < PORT_NUM);

    always_comb begin
        s_rvalid   = '0;
        w_m_rready = !w_rp_valid;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_rp_valid && (32'(w_rp) == p)) begin
                s_rvalid[p] = m_rvalid;
                w_m_rready  = s_rready[p];
            end
        end
    end

    assign m_rready = w_m_rready;
    assign s_ruser  = {PORT_NUM{m_ruser[S_USER_WIDTH-1:0]}};
    assign s_rlast  = {PORT_NUM{m_rlast}};
    assign s_rdata  = {PORT_NUM{m_rdata}};
    assign s_rstrb  = {PORT_NUM{m_rstrb}};

    // Count events per port. A decrement at zero (a stale beat from before
    // a reset) is dropped, so it cannot cancel a real increment either.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_inc[p] = s_arvalid[p] && s_arready[p];
            w_dec[p] = s_rvalid[p] && s_rready[p] && m_rlast && (r_cnt[p] != '0);
        end
    end

    // Outstanding counters, one per port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (w_inc[p] && !w_dec[p]) begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end else if (!w_inc[p] && w_dec[p]) begin
                    r_cnt[p] <= r_cnt[p] - 1'b1;
                end
            end
        end
    end

    // Sticky error flag for beats that carried a nonexistent port tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status_error <= 1'b0;
        end else if (m_rvalid && !w_rp_valid) begin
            r_status_error <= 1'b1;
        end
    end

    // Busy while anything is pending or outstanding.
    always_comb begin
        w_busy = r_m_arvalid;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (r_cnt[p] != '0) begin
                w_busy = 1'b1;
            end
        end
    end

    assign status_busy  = w_busy;
    assign status_error = r_status_error;

endmodule
